// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: ID/EX pipeline register with EX operand forwarding and load-use stall detection
module id_ex_fwd_stage #(
  parameter int instruction_width = 32,
  parameter int reg_addr_width    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [instruction_width-1:0] id_rs_data,
  input  logic [instruction_width-1:0] id_rt_data,
  input  logic [instruction_width-1:0] id_imm,
  input  logic [reg_addr_width-1:0]    id_rs,
  input  logic [reg_addr_width-1:0]    id_rt,
  input  logic [reg_addr_width-1:0]    id_rd,
  input  logic [3:0]                   id_alu_ctr,
  input  logic                         id_alu_src,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic                         id_mem_write,
  input  logic                         id_mem_to_reg,
  input  logic                         exmem_reg_write,
  input  logic [reg_addr_width-1:0]    exmem_rd,
  input  logic [instruction_width-1:0] exmem_y,
  input  logic                         memwb_reg_write,
  input  logic [reg_addr_width-1:0]    memwb_rd,
  input  logic [instruction_width-1:0] memwb_wdata,
  output logic                         stall_id,
  output logic [instruction_width-1:0] alu_a,
  output logic [instruction_width-1:0] alu_b,
  output logic [3:0]                   alu_ctr,
  output logic                         ex_valid,
  output logic [reg_addr_width-1:0]    ex_rd,
  output logic                         ex_reg_write,
  output logic                         ex_mem_read,
  output logic                         ex_mem_write,
  output logic                         ex_mem_to_reg,
  output logic [instruction_width-1:0] ex_store_data
);
  logic                         valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [reg_addr_width-1:0]    rs_q, rt_q, rd_q;
  logic [instruction_width-1:0] rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
  logic [3:0]                   alu_ctr_q;
  logic                         kill;

  assign stall_id = valid_q & mem_read_q & (rd_q != '0) & id_valid & ((rd_q == id_rs) | (rd_q == id_rt));
  // flush, load-use bubble and an empty decode slot all enter as a no-op with zeroed control
  assign kill = flush | stall_id | ~id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctr_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
    end else begin
      valid_q      <= ~kill;
      alu_src_q    <= ~kill & id_alu_src;
      reg_write_q  <= ~kill & id_reg_write;
      mem_read_q   <= ~kill & id_mem_read;
      mem_write_q  <= ~kill & id_mem_write;
      mem_to_reg_q <= ~kill & id_mem_to_reg;
      alu_ctr_q    <= kill ? 4'b0000 : id_alu_ctr;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      rd_q         <= id_rd;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
    end
  end

  always_comb begin
    fwd_rs = (rs_q != '0 && exmem_reg_write && exmem_rd == rs_q) ? exmem_y :
             (rs_q != '0 && memwb_reg_write && memwb_rd == rs_q) ? memwb_wdata : rs_data_q;
    fwd_rt = (rt_q != '0 && exmem_reg_write && exmem_rd == rt_q) ? exmem_y :
             (rt_q != '0 && memwb_reg_write && memwb_rd == rt_q) ? memwb_wdata : rt_data_q;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctr       = alu_ctr_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_mem_to_reg = valid_q & mem_to_reg_q;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb_id_ex_fwd_stage: directed checks of capture, forwarding, load-use stall, flush and async reset
module tb_id_ex_fwd_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [3:0]  id_alu_ctr = '0;
  logic        id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_mem_to_reg = 1'b0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_y = '0, memwb_wdata = '0;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctr;
  logic [4:0]  ex_rd;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctr(id_alu_ctr),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_y(exmem_y),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .stall_id(stall_id), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_store_data(ex_store_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [3:0] ctr,
                        input logic src, input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_alu_ctr = ctr; id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ex_valid_held", {31'b0, ex_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("idle_stall", {31'b0, stall_id}, 32'd0);
    chk("idle_alu_a", alu_a, 32'd0);
    chk("idle_alu_b", alu_b, 32'd0);
    chk("idle_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
    chk("idle_alu_ctr", {28'b0, alu_ctr}, 32'd0);

    set_id(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("cap_alu_a", alu_a, 32'd5);
    chk("cap_alu_b", alu_b, 32'd7);
    chk("cap_alu_ctr", {28'b0, alu_ctr}, 32'h2);
    chk("cap_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("cap_reg_write", {31'b0, ex_reg_write}, 32'd1);
    chk("cap_ex_rd", {27'b0, ex_rd}, 32'd4);

    set_id(5'd3, 5'd2, 5'd4, 32'h11, 32'd7, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_y = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wdata = 32'hBB;
    #1 chk("fwd_exmem_prio", alu_a, 32'hAA);
    exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb", alu_a, 32'hBB);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    #1 chk("fwd_none", alu_a, 32'h11);
    set_id(5'd0, 5'd2, 5'd4, 32'h22, 32'd7, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    #1 chk("fwd_r0_blocked", alu_a, 32'h22);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    set_id(5'd1, 5'd6, 5'd0, 32'd1, 32'd9, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    id_imm = 32'hFFFF_FFF0;
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_y = 32'h1234;
    #1 chk("imm_alu_b", alu_b, 32'hFFFF_FFF0);
    chk("store_data_fwd", ex_store_data, 32'h1234);
    chk("store_mem_write", {31'b0, ex_mem_write}, 32'd1);
    exmem_reg_write = 1'b0;

    set_id(5'd1, 5'd8, 5'd8, 32'd0, 32'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("lw_mem_read", {31'b0, ex_mem_read}, 32'd1);
    set_id(5'd8, 5'd2, 5'd9, 32'd0, 32'd3, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_stall_on", {31'b0, stall_id}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("lu_stall_off", {31'b0, stall_id}, 32'd0);
    step();
    memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_wdata = 32'h5555;
    #1 chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_add_alu_a", alu_a, 32'h5555);
    chk("lu_add_alu_b", alu_b, 32'd3);
    memwb_reg_write = 1'b0;

    set_id(5'd1, 5'd8, 5'd8, 32'd0, 32'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_id(5'd8, 5'd2, 5'd0, 32'd0, 32'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("fl_stall_on", {31'b0, stall_id}, 32'd1);
    step();
    flush = 1'b0;
    chk("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_mem_write", {31'b0, ex_mem_write}, 32'd0);

    set_id(5'd1, 5'd8, 5'd8, 32'h77, 32'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_id(5'd8, 5'd2, 5'd9, 32'd0, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("ar_pre_valid", {31'b0, ex_valid}, 32'd1);
    chk("ar_pre_stall", {31'b0, stall_id}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("ar_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("ar_stall", {31'b0, stall_id}, 32'd0);
    chk("ar_alu_a", alu_a, 32'd0);
    chk("ar_mem_read", {31'b0, ex_mem_read}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
ID/EX pipeline register for the 5-stage CPU, with operand forwarding and load-use hazard detection. It captures decoded operands and control from the decode stage each cycle. It drives the ALU operand and control inputs (a, b, alu_ctr) directly. It carries memory/writeback control and the destination register forward to the EX/MEM register.

Parameters:
instruction_width, 32, datapath width of operands, immediate and forwarded results
reg_addr_width, 5, register-file index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  branch/jump taken: squash the instruction entering ID/EX
id_valid  input  1  decode stage holds a real instruction
id_rs_data  input  instruction_width  register-file read of rs
id_rt_data  input  instruction_width  register-file read of rt
id_imm  input  instruction_width  sign-extended immediate
id_rs  input  reg_addr_width  rs index
id_rt  input  reg_addr_width  rt index
id_rd  input  reg_addr_width  destination index (already rt/rd-selected)
id_alu_ctr  input  4  ALU control code
id_alu_src  input  1  1 = ALU b from immediate
id_reg_write  input  1  writes register file
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  writeback from memory
exmem_reg_write  input  1  EX/MEM instruction writes a register
exmem_rd  input  reg_addr_width  EX/MEM destination
exmem_y  input  instruction_width  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB instruction writes a register
memwb_rd  input  reg_addr_width  MEM/WB destination
memwb_wdata  input  instruction_width  MEM/WB writeback value
stall_id  output  1  hold PC and IF/ID this cycle (load-use bubble)
alu_a  output  instruction_width  forwarded rs operand to ALU
alu_b  output  instruction_width  forwarded rt operand or immediate to ALU
alu_ctr  output  4  registered ALU control
ex_valid  output  1  ID/EX holds a real instruction
ex_rd  output  reg_addr_width  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control, forced 0 when ex_valid=0
ex_store_data  output  instruction_width  forwarded rt value for stores

Behaviour:
- Reset: all registered fields 0, so ex_valid=0, all control 0, alu_ctr=4'b0000, and alu_a/alu_b resolve to 0. Reset is asynchronous on assertion and takes effect without waiting for a clock edge.
- Load-use hazard (combinational): stall_id = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
  - rt is compared for all instruction types; this is conservative, and a spurious stall costs one cycle only.
- Register update on each rising edge, in priority order:
  1. flush=1: load a bubble. ex_valid and all control go to 0; data fields are don't-care. flush overrides stall.
  2. stall_id=1: load a bubble. Upstream holds IF/ID, so the same instruction re-presents next cycle and no longer hazards.
  3. Otherwise: capture all id_* fields; ex_valid <= id_valid.
- Control gating: with id_valid=0, captured control is forced to 0.
- Forwarding (combinational on registered rs/rt, applied independently to each operand):
  - Source index 0 is never forwarded; the registered data is used.
  - Priority 1: exmem_reg_write & exmem_rd==src selects exmem_y.
  - Priority 2: memwb_reg_write & memwb_rd==src selects memwb_wdata.
  - Else: the registered register-file data.
- Operand outputs: alu_a = forwarded rs. alu_b = ex_alu_src ? ex_imm : forwarded rt. ex_store_data = forwarded rt, regardless of alu_src.
- Latency:
  - One cycle from id_* to alu_ctr/alu_a/alu_b.
  - Forwarding muxes are zero-latency relative to exmem_*/memwb_*.
  - A load followed immediately by a dependent instruction incurs exactly 1 bubble; the value then arrives via the MEM/WB path.
- No width extension: all values are passed at instruction_width.
- Reset mid-stream: any in-flight instruction is lost; stall_id deasserts immediately because ex_valid=0.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then release with id_valid=0 -> ex_valid=0, stall_id=0, alu_a=alu_b=0, all ex_* control 0.
- Plain capture: id_rs_data=5, id_rt_data=7, alu_ctr=0010, no hazard match -> next cycle alu_a=5, alu_b=7, alu_ctr=0010, ex_valid=1.
- Forwarding priority: ID/EX rs=3; exmem_rd=3, exmem_y=0xAA; memwb_rd=3, memwb_wdata=0xBB -> alu_a=0xAA. Drop exmem_reg_write -> alu_a=0xBB. Set rs=0 with exmem_rd=0 -> alu_a = registered data.
- Immediate vs store data: alu_src=1, imm=0xFFFF_FFF0, rt forwarded from exmem_y=0x1234 -> alu_b=0xFFFF_FFF0, ex_store_data=0x1234.
- Load-use: lw into r8 in ID/EX, dependent add with rs=8 in ID -> stall_id=1 for exactly 1 cycle. Next cycle ex_valid=0 (bubble); the following cycle the add is captured with alu_a taken from memwb_wdata.
- Flush during stall: hazard active and flush=1 -> bubble loaded, ex_valid=0, ex_mem_write=0. Separately, asserting rst_n=0 between clock edges clears ex_valid immediately.
